// File: rtl/led_counter_if.sv
// LED bank bus: the 5-bit display field driven by the counter.
`timescale 1ns/1ps
interface led_counter_if;
    logic [4:0] leds;

    modport master (output leds);
    modport slave  (input  leds);
endinterface

// File: rtl/led_counter.sv
// Free-running N-bit heartbeat counter; the top 5 bits drive an LED bank.
// Large N slows the visible pattern; the field wraps every 2^N clocks.
`timescale 1ns/1ps
module led_counter #(
    parameter int N = 26
) (
    input  logic          clk,
    input  logic          rst,
    led_counter_if.master bus
);

    // Reject widths outside 1..32 at elaboration.
    if (N < 1 || N > 32) begin : g_bad_n
        $error("led_counter: N must be in 1..32");
    end

    // Power-up value 0 so the counter runs even if rst is never driven.
    logic [N-1:0] cnt = '0;

    // Count every edge; only a definite 1 on rst clears (X falls to the count branch).
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + N'(1);
    end

    // LEDs are a pure slice of the registered count: MSB field, or zero-extended when narrow.
    if (N >= 5) begin : g_wide
        assign bus.leds = cnt[N-1:N-5];
    end else begin : g_narrow
        assign bus.leds = {{(5-N){1'b0}}, cnt};
    end

endmodule

// File: tb/tb_led_counter.sv
// Bench for led_counter: several widths run side by side against an edge-count model.
`timescale 1ns/1ps
module tb_led_counter;

    logic clk = 1'b0;
    logic rst_a;          // never driven: counter must still run
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;
    logic rst_d = 1'b0;
    logic rst_e = 1'b0;

    led_counter_if if_a ();
    led_counter_if if_b ();
    led_counter_if if_c ();
    led_counter_if if_d ();
    led_counter_if if_e ();

    led_counter #(.N(6))  dut_a (.clk(clk), .rst(rst_a), .bus(if_a));
    led_counter #(.N(6))  dut_b (.clk(clk), .rst(rst_b), .bus(if_b));
    led_counter #(.N(3))  dut_c (.clk(clk), .rst(rst_c), .bus(if_c));
    led_counter #(.N(5))  dut_d (.clk(clk), .rst(rst_d), .bus(if_d));
    led_counter #(.N(26)) dut_e (.clk(clk), .rst(rst_e), .bus(if_e));

    always #50 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Edges since start, and edges since each DUT last saw reset.
    longint edges = 0;
    longint since_a = 0, since_b = 0, since_c = 0, since_d = 0, since_e = 0;

    always @(posedge clk) begin
        edges   <= edges + 1;
        since_a <= (rst_a === 1'b1) ? 0 : since_a + 1;
        since_b <= (rst_b === 1'b1) ? 0 : since_b + 1;
        since_c <= (rst_c === 1'b1) ? 0 : since_c + 1;
        since_d <= (rst_d === 1'b1) ? 0 : since_d + 1;
        since_e <= (rst_e === 1'b1) ? 0 : since_e + 1;
    end

    // Display value after s counting edges for an n-bit counter.
    function automatic logic [4:0] exp_leds(input longint s, input int n);
        longint v;
        v = s % (longint'(1) << n);
        if (n >= 5) v = v >> (n - 5);
        return v[4:0];
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @edge %0d: got %b, expected %b", name, edges, act, exp);
        end
    endtask

    initial begin
        // Reset/power-up state before any edge.
        #10;
        chk("init_a", if_a.leds, 5'b00000);
        chk("init_e", if_e.leds, 5'b00000);

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            // Model comparison every cycle.
            chk("model_a", if_a.leds, exp_leds(since_a, 6));
            chk("model_b", if_b.leds, exp_leds(since_b, 6));
            chk("model_c", if_c.leds, exp_leds(since_c, 3));
            chk("model_d", if_d.leds, exp_leds(since_d, 5));
            chk("model_e", if_e.leds, exp_leds(since_e, 26));
            if ($isunknown(if_e.leds)) begin
                tests++;
                fails++;
                $display("FAIL xcheck_e @edge %0d: got %b, expected no X", edges, if_e.leds);
            end

            // Hand-computed spot checks.
            case (edges)
                2:   chk("a_k2",   if_a.leds, 5'd1);
                9:   chk("c_k9",   if_c.leds, 5'b00001);
                33:  chk("d_k33",  if_d.leds, 5'd1);
                41:  chk("b_rst1", if_b.leds, 5'd0);
                43:  chk("b_rst3", if_b.leds, 5'd0);
                45:  chk("b_rel2", if_b.leds, 5'd1);
                63:  chk("a_k63",  if_a.leds, 5'd31);
                64:  chk("a_k64",  if_a.leds, 5'd0);
                106: chk("b_pre_wrap",  if_b.leds, 5'd31);
                107: chk("b_wrap_rst",  if_b.leds, 5'd0);
                108: chk("b_post_wrap", if_b.leds, 5'd0);
                109: chk("b_resume",    if_b.leds, 5'd1);
                130: chk("a_k130", if_a.leds, 5'd1);
                999: chk("e_k999", if_e.leds, 5'd0);
                default: ;
            endcase

            // Reset on edges 41..43, then on the 63->0 wrap edge (107).
            rst_b = ((edges >= 40 && edges < 43) || edges == 106) ? 1'b1 : 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
